// File: rtl/mw_fifo.sv
// Multi-lane write, single-lane read FIFO: up to WRITE_PORTS entries enqueued per cycle,
// one registered entry popped per cycle, with a sticky overflow flag for rejected batches.
module mw_fifo_lane #(
    parameter int AW   = 4,
    parameter int LANE = 0
) (
    input  logic [AW:0]   wr_ptr_i,
    input  logic [2:0]    wcount_i,
    input  logic          accept_i,
    output logic          we_o,
    output logic [AW-1:0] idx_o
);
    // Lane offset wraps modulo depth, so a batch crossing the end of storage needs no special case.
    assign we_o  = accept_i && (wcount_i > 3'(LANE));
    assign idx_o = wr_ptr_i[AW-1:0] + AW'(LANE);
endmodule

module mw_fifo #(
    parameter int DATA_WIDTH    = 65,
    parameter int ADDRESS_WIDTH = 4,
    parameter int WRITE_PORTS   = 2,
    parameter int AF_MARGIN     = 2
) (
    input  logic                              Clk,
    input  logic                              Reset_n_in,
    input  logic                              Clear_in,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] Data_in,
    input  logic [2:0]                        WriteCount_in,
    output logic                              Full_out,
    output logic                              AlmostFull_out,
    output logic                              Overflow_err,
    input  logic                              stall,
    input  logic                              ReadEn_in,
    output logic [DATA_WIDTH-1:0]             Data_out,
    output logic                              Data_valid,
    output logic                              Empty_out,
    output logic [ADDRESS_WIDTH:0]            Count_out
);
    localparam int AW    = ADDRESS_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int PW    = AW + 1;
    localparam int CW    = AW + 4;
    localparam int DEPTH = 1 << AW;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic          ovf_q, ovf_d, dv_q, dv_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] mem [DEPTH];
    logic [CW-1:0] wc_w, space_w;
    logic          wr_req, wr_ok, pop;
    logic [WRITE_PORTS-1:0]         lane_we;
    logic [WRITE_PORTS-1:0][AW-1:0] lane_idx;

    // All status flags derive from registered pointers only.
    assign count          = wr_ptr_q - rd_ptr_q;
    assign Count_out      = count;
    assign Empty_out      = (count == '0);
    assign Full_out       = (count > PW'(DEPTH - WRITE_PORTS));
    assign AlmostFull_out = (count >= PW'(DEPTH - AF_MARGIN));
    assign Overflow_err   = ovf_q;
    assign Data_valid     = dv_q;
    assign Data_out       = dout_q;

    assign wc_w    = CW'(WriteCount_in);
    assign space_w = CW'(PW'(DEPTH) - count);

    always_comb begin
        wr_req   = (WriteCount_in != 3'd0) && !Clear_in;
        wr_ok    = wr_req && (wc_w <= CW'(WRITE_PORTS)) && (wc_w <= space_w);
        pop      = ReadEn_in && !stall && !Empty_out && !Clear_in;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        dv_d     = 1'b0;
        dout_d   = dout_q;
        if (Clear_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr_d = wr_ptr_q + PW'(WriteCount_in);
            else if (wr_req)
                ovf_d = 1'b1;
            // Pop decision uses pre-edge occupancy, so a same-cycle write never falls through.
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                dout_d   = mem[rd_ptr_q[AW-1:0]];
                dv_d     = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < WRITE_PORTS; i++) begin : g_lane
        mw_fifo_lane #(.AW(AW), .LANE(i)) u_lane (
            .wr_ptr_i (wr_ptr_q),
            .wcount_i (WriteCount_in),
            .accept_i (wr_ok),
            .we_o     (lane_we[i]),
            .idx_o    (lane_idx[i])
        );
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < WRITE_PORTS; i++)
            if (lane_we[i]) mem[lane_idx[i]] <= Data_in[i*DW +: DW];
    end

    always_ff @(posedge Clk or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            dv_q     <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            dv_q     <= dv_d;
            dout_q   <= dout_d;
        end
    end
endmodule

// File: tb/tb_mw_fifo.sv
// Directed bench for mw_fifo: a queue-based reference model checked every cycle,
// plus literal expectations at the key scenario points.
module tb_mw_fifo;
    localparam int DW = 65;
    localparam int AW = 4;
    localparam int WP = 2;
    localparam int AFM = 2;
    localparam int DEPTH = 1 << AW;

    logic              Clk, Reset_n_in, Clear_in, stall, ReadEn_in;
    logic [WP*DW-1:0]  Data_in;
    logic [2:0]        WriteCount_in;
    logic              Full_out, AlmostFull_out, Overflow_err, Data_valid, Empty_out;
    logic [DW-1:0]     Data_out;
    logic [AW:0]       Count_out;

    int checks = 0;
    int errors = 0;

    mw_fifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WRITE_PORTS(WP), .AF_MARGIN(AFM)) dut (
        .Clk(Clk), .Reset_n_in(Reset_n_in), .Clear_in(Clear_in), .Data_in(Data_in),
        .WriteCount_in(WriteCount_in), .Full_out(Full_out), .AlmostFull_out(AlmostFull_out),
        .Overflow_err(Overflow_err), .stall(stall), .ReadEn_in(ReadEn_in), .Data_out(Data_out),
        .Data_valid(Data_valid), .Empty_out(Empty_out), .Count_out(Count_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of entries plus the visible read/flag state.
    logic [DW-1:0] m_q[$];
    logic          m_ovf, m_dv;
    logic [DW-1:0] m_dout;

    always @(posedge Clk or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_dv   = 1'b0;
            m_dout = '0;
        end else begin
            int  n;
            int  wc;
            bit  do_pop, do_wr;
            n      = m_q.size();
            wc     = int'(WriteCount_in);
            do_pop = ReadEn_in && !stall && n != 0 && !Clear_in;
            do_wr  = wc != 0 && wc <= WP && wc <= DEPTH - n && !Clear_in;
            if (Clear_in) begin
                m_q.delete();
                m_ovf = 1'b0;
                m_dv  = 1'b0;
            end else begin
                m_dv = do_pop;
                if (do_pop) m_dout = m_q.pop_front();
                if (do_wr) begin
                    for (int i = 0; i < wc; i++) m_q.push_back(Data_in[i*DW +: DW]);
                end else if (wc != 0) m_ovf = 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        int n;
        n = m_q.size();
        chk("m_count", 128'(Count_out), 128'(n));
        chk("m_empty", 128'(Empty_out), 128'(n == 0));
        chk("m_full",  128'(Full_out),  128'(n > DEPTH - WP));
        chk("m_afull", 128'(AlmostFull_out), 128'(n >= DEPTH - AFM));
        chk("m_ovf",   128'(Overflow_err), 128'(m_ovf));
        chk("m_dv",    128'(Data_valid), 128'(m_dv));
        chk("m_dout",  128'(Data_out), 128'(m_dout));
    end

    task automatic cyc(input int wc, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input bit rd, input bit st, input bit clr);
        WriteCount_in = 3'(wc);
        Data_in       = {d1, d0};
        ReadEn_in     = rd;
        stall         = st;
        Clear_in      = clr;
        @(posedge Clk);
        #1;
        WriteCount_in = 3'd0;
        ReadEn_in     = 1'b0;
        stall         = 1'b0;
        Clear_in      = 1'b0;
    endtask

    localparam logic [DW-1:0] A = 65'h1_0000_0000_0000_00A1;
    localparam logic [DW-1:0] B = 65'h0_8000_0000_0000_00B2;
    localparam logic [DW-1:0] X = 65'h1_2345_6789_ABCD_EF01;
    localparam logic [DW-1:0] Y = 65'h0_FEDC_BA98_7654_3210;
    localparam logic [DW-1:0] C = 65'h1_C0C0_C0C0_C0C0_C0C0;
    localparam logic [DW-1:0] P = 65'h0_0000_0000_0000_5555;
    localparam logic [DW-1:0] Q = 65'h1_AAAA_0000_0000_0000;

    initial begin
        Reset_n_in = 1'b0; Clear_in = 1'b0; stall = 1'b0; ReadEn_in = 1'b0;
        WriteCount_in = 3'd0; Data_in = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_count", 128'(Count_out), 128'd0);
        chk("rst_empty", 128'(Empty_out), 128'd1);
        chk("rst_full",  128'(Full_out), 128'd0);
        chk("rst_afull", 128'(AlmostFull_out), 128'd0);
        chk("rst_ovf",   128'(Overflow_err), 128'd0);
        chk("rst_dv",    128'(Data_valid), 128'd0);
        chk("rst_dout",  128'(Data_out), 128'd0);
        Reset_n_in = 1'b1;

        // Two-lane write then two pops.
        cyc(2, A, B, 0, 0, 0);
        chk("w2_count", 128'(Count_out), 128'd2);
        cyc(0, '0, '0, 1, 0, 0);
        chk("pop1_dv", 128'(Data_valid), 128'd1);
        chk("pop1_dout", 128'(Data_out), 128'(A));
        chk("pop1_count", 128'(Count_out), 128'd1);
        cyc(0, '0, '0, 1, 0, 0);
        chk("pop2_dout", 128'(Data_out), 128'(B));
        chk("pop2_count", 128'(Count_out), 128'd0);
        cyc(0, '0, '0, 0, 0, 0);
        chk("idle_dv", 128'(Data_valid), 128'd0);
        chk("idle_hold", 128'(Data_out), 128'(B));

        // Fill to full with two-lane writes, then overflow.
        for (int k = 0; k < 8; k++) begin
            cyc(2, DW'(10 + 2*k), DW'(11 + 2*k), 0, 0, 0);
            if (k == 6) begin
                chk("c14_afull", 128'(AlmostFull_out), 128'd1);
                chk("c14_full",  128'(Full_out), 128'd0);
            end
        end
        chk("c16_count", 128'(Count_out), 128'd16);
        chk("c16_full",  128'(Full_out), 128'd1);
        cyc(1, DW'(99), '0, 0, 0, 0);
        chk("ovf_set",   128'(Overflow_err), 128'd1);
        chk("ovf_count", 128'(Count_out), 128'd16);

        // Clear beats a concurrent write and pop.
        cyc(2, DW'(77), DW'(78), 1, 0, 1);
        chk("clr_count", 128'(Count_out), 128'd0);
        chk("clr_empty", 128'(Empty_out), 128'd1);
        chk("clr_ovf",   128'(Overflow_err), 128'd0);
        chk("clr_dv",    128'(Data_valid), 128'd0);

        // Fill to 15, drain so both pointers sit at index 15, then a wrapping write.
        for (int k = 0; k < 7; k++) cyc(2, DW'(100 + 2*k), DW'(101 + 2*k), 0, 0, 0);
        cyc(1, DW'(114), '0, 0, 0, 0);
        chk("c15_full",  128'(Full_out), 128'd1);
        chk("c15_count", 128'(Count_out), 128'd15);
        for (int k = 0; k < 15; k++) begin
            cyc(0, '0, '0, 1, 0, 0);
            if (k == 0) chk("drain_first", 128'(Data_out), 128'd100);
        end
        chk("drain_last", 128'(Data_out), 128'd114);
        cyc(2, X, Y, 0, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);
        chk("wrap_x", 128'(Data_out), 128'(X));
        cyc(0, '0, '0, 1, 0, 0);
        chk("wrap_y", 128'(Data_out), 128'(Y));

        // No fall-through on empty; write+pop nets n-1.
        cyc(1, C, '0, 1, 0, 0);
        chk("nft_dv",    128'(Data_valid), 128'd0);
        chk("nft_count", 128'(Count_out), 128'd1);
        cyc(2, DW'(201), DW'(202), 0, 0, 0);
        cyc(2, DW'(203), DW'(204), 0, 0, 0);
        cyc(2, DW'(205), DW'(206), 1, 0, 0);
        chk("wp_count", 128'(Count_out), 128'd6);
        chk("wp_dout",  128'(Data_out), 128'(C));

        // Stall blocks pop; oversize batch is rejected whole.
        cyc(0, '0, '0, 1, 1, 0);
        chk("stall_dv",    128'(Data_valid), 128'd0);
        chk("stall_count", 128'(Count_out), 128'd6);
        cyc(3, DW'(301), DW'(302), 0, 0, 0);
        chk("wc3_ovf",   128'(Overflow_err), 128'd1);
        chk("wc3_count", 128'(Count_out), 128'd6);
        cyc(2, DW'(207), DW'(208), 0, 0, 0);
        cyc(1, DW'(209), '0, 0, 0, 0);
        chk("c9_count", 128'(Count_out), 128'd9);

        // Asynchronous reset mid-cycle, observed before the next edge.
        #2 Reset_n_in = 1'b0;
        #1;
        chk("ar_count", 128'(Count_out), 128'd0);
        chk("ar_empty", 128'(Empty_out), 128'd1);
        chk("ar_ovf",   128'(Overflow_err), 128'd0);
        chk("ar_dout",  128'(Data_out), 128'd0);
        chk("ar_afull", 128'(AlmostFull_out), 128'd0);
        @(posedge Clk);
        #1 Reset_n_in = 1'b1;
        cyc(2, P, Q, 0, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);
        chk("post_p", 128'(Data_out), 128'(P));
        cyc(0, '0, '0, 1, 0, 0);
        chk("post_q", 128'(Data_out), 128'(Q));
        cyc(0, '0, '0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mw_fifo.md
MW_FIFO -- requirements
Module: mw_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 65: width of one FIFO entry.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4: FIFO_DEPTH = 2^ADDRESS_WIDTH entries.
REQ-003 SHALL have parameter WRITE_PORTS, default 2, legal range 1..4: maximum entries written per cycle.
REQ-004 SHALL have parameter AF_MARGIN, default 2: almost-full threshold distance from FIFO_DEPTH.
REQ-005 Clk  input  1  sole clock; all logic rising-edge.
REQ-006 Reset_n_in  input  1  asynchronous, active-low reset.
REQ-007 Clear_in  input  1  synchronous flush, active-high.
REQ-008 Data_in  input  WRITE_PORTS*DATA_WIDTH  write lanes; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 WriteCount_in  input  3  number of valid lanes this cycle, packed from lane 0; 0 means no write.
REQ-010 Full_out  output  1  FIFO cannot accept a full WRITE_PORTS batch.
REQ-011 AlmostFull_out  output  1  occupancy >= FIFO_DEPTH - AF_MARGIN.
REQ-012 Overflow_err  output  1  sticky: a write was rejected.
REQ-013 stall  input  1  downstream stall; blocks pops.
REQ-014 ReadEn_in  input  1  pop request.
REQ-015 Data_out  output  DATA_WIDTH  registered read data.
REQ-016 Data_valid  output  1  Data_out holds a newly popped entry this cycle.
REQ-017 Empty_out  output  1  occupancy is zero.
REQ-018 Count_out  output  ADDRESS_WIDTH+1  current occupancy, 0..FIFO_DEPTH.

Function
REQ-019 SHALL keep binary read/write pointers of ADDRESS_WIDTH+1 bits; storage index = low ADDRESS_WIDTH bits; extra bit resolves full vs empty at wrap.
REQ-020 SHALL compute Count_out = wr_ptr - rd_ptr modulo 2^(ADDRESS_WIDTH+1), registered-pointer derived (no input-to-output combinational path).
REQ-021 SHALL drive Empty_out = (Count_out == 0); Full_out = (Count_out > FIFO_DEPTH - WRITE_PORTS); AlmostFull_out = (Count_out >= FIFO_DEPTH - AF_MARGIN).
REQ-022 SHALL accept a write when 0 < WriteCount_in <= WRITE_PORTS and WriteCount_in <= FIFO_DEPTH - Count_out and Clear_in = 0.
REQ-023 On accepted write SHALL store lane i at index (wr_ptr + i) mod FIFO_DEPTH for i < WriteCount_in, and advance wr_ptr by WriteCount_in; wrap mid-batch SHALL be seamless.
REQ-024 A write not meeting REQ-022 (insufficient space or WriteCount_in > WRITE_PORTS) SHALL be rejected whole: no storage or pointer change, Overflow_err set next cycle.
REQ-025 Overflow_err SHALL stay 1 until Reset_n_in low or Clear_in high.
REQ-026 SHALL pop when ReadEn_in = 1, stall = 0, Empty_out = 0; rd_ptr advances by 1.
REQ-027 On a pop, next cycle Data_out = entry at old rd_ptr and Data_valid = 1 (latency 1); otherwise Data_valid = 0 and Data_out holds its value.
REQ-028 Empty/space decisions SHALL use pre-edge Count_out: no write-to-read fall-through; simultaneous pop SHALL NOT free space for a same-cycle write.
REQ-029 Simultaneous accepted write of n and pop SHALL give Count_out(next) = Count_out + n - 1.
REQ-030 Clear_in SHALL take priority over same-cycle writes and pops: pointers 0, Data_valid 0, Overflow_err 0; storage contents unchanged; Data_out holds.

Reset
REQ-031 Reset_n_in low SHALL immediately, without clock: pointers 0, Count_out 0, Empty_out 1, Full_out 0, AlmostFull_out 0, Overflow_err 0, Data_valid 0, Data_out 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries; first accepted write after release SHALL land at index 0.
REQ-033 Storage array SHALL NOT require reset.

Verification (defaults: DATA_WIDTH 65, depth 16, WRITE_PORTS 2, AF_MARGIN 2)
REQ-034 Reset, write WriteCount_in=2 lanes {A,B}, then ReadEn_in 2 cycles -> Count_out 2 then 0; Data_valid pulses with Data_out A then B, one cycle after each pop.
REQ-035 Eight 2-lane writes -> Count_out 16, Full_out 1 from Count 15 onward, AlmostFull_out 1 at Count 14; further 1-lane write -> rejected, Overflow_err 1, Count_out stays 16.
REQ-036 Fill to 15, pop to rd_ptr 15, write 2 lanes {X,Y} at wr index 15 -> X stored at 15, Y at 0; pops return X then Y in order.
REQ-037 Empty FIFO, same cycle write 1 + ReadEn_in -> no pop, Data_valid 0, Count_out 1; Count 5 with write 2 + pop -> Count_out 6.
REQ-038 Count 6, stall 1 with ReadEn_in 1 -> no pop, Data_valid 0; Clear_in with concurrent write -> Count_out 0, Empty_out 1, Overflow_err 0.
REQ-039 Reset_n_in pulsed low asynchronously at Count 9 -> outputs per REQ-031 before next Clk edge.
